// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding, percent limit and clamp helper for the PWM power stage.
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, SOFT, RUN, FAULT} state_t;

    localparam int unsigned PCT_MAX = 100;

    function automatic int unsigned clamp_pct(input int unsigned p);
        return (p > PCT_MAX) ? PCT_MAX : p;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus phase counter; both held at zero while run is low.
module pwm_timebase #(
    parameter int PERIOD   = 100,
    parameter int PRESCALE = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    output logic                      tick,
    output logic [$clog2(PERIOD)-1:0] phase,
    output logic                      boundary
);
    localparam int HW = $clog2(PERIOD);
    localparam int PW = $clog2(PRESCALE + 1);

    logic [PW-1:0] pre;

    assign tick     = pre == PW'(PRESCALE - 1);
    assign boundary = tick && phase == HW'(PERIOD - 1);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            pre   <= '0;
            phase <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick)
                phase <= boundary ? '0 : phase + HW'(1);
        end
    end
endmodule

// File: rtl/pwm_power_stage.sv
// pwm_power_stage: soft-started, period-aligned PWM drive with a latched persistent-saturation fault.
module pwm_power_stage
    import pwm_pkg::*;
#(
    parameter int N         = 8,
    parameter int PERIOD    = 100,
    parameter int PRESCALE  = 10,
    parameter int RAMP_STEP = 1,
    parameter int SAT_LIMIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] percent,
    input  logic         sat,
    input  logic         clr_fault,
    output logic         pwm_out,
    output logic [N-1:0] duty_active,
    output logic         period_start,
    output logic         fault
);
    localparam int HW = $clog2(PERIOD);
    localparam int SW = $clog2(SAT_LIMIT + 1);

    state_t        state, nxt;
    logic          tick, boundary, active, run, bnd, trip;
    logic [HW-1:0] phase;
    logic [N-1:0]  target, ramp, duty_nxt;
    logic [SW-1:0] sat_cnt, cnt_nxt;
    logic [31:0]   up, sat_inc;

    // Counters run only while the stage stays active across the edge, so they sit at 0 on entry and exit.
    pwm_timebase #(.PERIOD(PERIOD), .PRESCALE(PRESCALE)) u_tb (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .tick     (tick),
        .phase    (phase),
        .boundary (boundary)
    );

    assign active  = state == SOFT || state == RUN;
    assign run     = active && (nxt == SOFT || nxt == RUN);
    assign bnd     = active && tick && boundary;
    assign target  = N'(clamp_pct(32'(percent)));
    assign up      = 32'(duty_active) + 32'(RAMP_STEP);
    assign ramp    = (up > 32'(target)) ? target : N'(up);
    assign sat_inc = 32'(sat_cnt) + 32'd1;
    assign trip    = bnd && sat && sat_inc >= 32'(SAT_LIMIT);

    always_comb begin
        nxt      = state;
        duty_nxt = duty_active;
        cnt_nxt  = sat_cnt;
        case (state)
            IDLE: begin
                duty_nxt = '0;
                cnt_nxt  = '0;
                nxt      = en ? SOFT : IDLE;
            end
            SOFT, RUN: begin
                if (bnd) begin
                    cnt_nxt  = sat ? SW'(sat_inc) : '0;
                    duty_nxt = (state == SOFT) ? ramp : target;
                    nxt      = (state == SOFT && ramp == target) ? RUN : state;
                end
                if (trip || !en) begin
                    nxt      = trip ? FAULT : IDLE;
                    duty_nxt = '0;
                    cnt_nxt  = '0;
                end
            end
            default: begin
                duty_nxt = '0;
                cnt_nxt  = '0;
                nxt      = (clr_fault && !en) ? IDLE : FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            duty_active  <= '0;
            sat_cnt      <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= nxt;
            duty_active  <= duty_nxt;
            sat_cnt      <= cnt_nxt;
            pwm_out      <= run && 32'(phase) < 32'(duty_active);
            period_start <= bnd;
            fault        <= nxt == FAULT;
        end
    end
endmodule

// File: tb/tb_pwm_power_stage.sv
// tb_pwm_power_stage: scoreboard bench; expected per-period duty/high-count pushed with stimulus, popped per period.
module tb_pwm_power_stage;
    logic       clk, rst, en, sat, clr_fault;
    logic [7:0] percent;
    logic       pwm_out, period_start, fault;
    logic [7:0] duty_active;

    typedef struct {int duty; int highs;} exp_t;
    exp_t sb[$];
    int   fq[$];
    int   checks = 0;
    int   errors = 0;

    pwm_power_stage #(.N(8), .PERIOD(100), .PRESCALE(1), .RAMP_STEP(10), .SAT_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .percent      (percent),
        .sat          (sat),
        .clr_fault    (clr_fault),
        .pwm_out      (pwm_out),
        .duty_active  (duty_active),
        .period_start (period_start),
        .fault        (fault)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Window runs from a period_start cycle to the next one inclusive: exactly one period of pwm_out.
    task automatic measure(output int d, output int h, output bit ok);
        int n = 0;
        ok = 1;
        h = 0;
        d = -1;
        while (!period_start) begin
            @(negedge clk);
            n++;
            if (n > 300) begin ok = 0; return; end
        end
        d = int'(duty_active);
        do begin
            @(negedge clk);
            h += int'(pwm_out);
            n++;
            if (n > 400) begin ok = 0; return; end
        end while (!period_start);
    endtask

    task automatic test_reset;
        rst = 1; en = 1; percent = 80; sat = 0; clr_fault = 0;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset pwm_out got %b want 0", pwm_out); end
        checks++; if (duty_active !== 8'd0) begin errors++; $display("FAIL reset duty got %0d want 0", duty_active); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset fault got %b want 0", fault); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset period_start got %b want 0", period_start); end
        en = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_soft_start;
        int d, h; bit ok; exp_t e;
        percent = 50; en = 1;
        for (int k = 1; k <= 5; k++) sb.push_back('{k * 10, k * 10});
        sb.push_back('{50, 50});
        sb.push_back('{50, 50});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            measure(d, h, ok);
            checks++; if (!ok) begin errors++; $display("FAIL soft timeout got none want duty %0d", e.duty); end
            checks++; if (d != e.duty) begin errors++; $display("FAIL soft duty got %0d want %0d", d, e.duty); end
            checks++; if (h != e.highs) begin errors++; $display("FAIL soft highs got %0d want %0d", h, e.highs); end
        end
    endtask

    task automatic test_extremes;
        int d, h; bit ok; exp_t e;
        percent = 120;
        sb.push_back('{50, 50}); sb.push_back('{100, 100}); sb.push_back('{100, 100});
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            measure(d, h, ok);
            checks++; if (!ok || d != e.duty || h != e.highs) begin errors++; $display("FAIL clamp got %0d/%0d want %0d/%0d", d, h, e.duty, e.highs); end
        end
        percent = 0;
        sb.push_back('{100, 100}); sb.push_back('{0, 0}); sb.push_back('{0, 0});
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            measure(d, h, ok);
            checks++; if (!ok || d != e.duty || h != e.highs) begin errors++; $display("FAIL zero got %0d/%0d want %0d/%0d", d, h, e.duty, e.highs); end
        end
        percent = 30;
        sb.push_back('{0, 0}); sb.push_back('{30, 30});
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            measure(d, h, ok);
            checks++; if (!ok || d != e.duty || h != e.highs) begin errors++; $display("FAIL to30 got %0d/%0d want %0d/%0d", d, h, e.duty, e.highs); end
        end
    endtask

    task automatic test_mid_period;
        int d, h; bit ok; exp_t e;
        sb.push_back('{30, 30}); sb.push_back('{70, 70});
        e = sb.pop_front();
        d = int'(duty_active);
        h = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) percent = 70;
            @(negedge clk);
            h += int'(pwm_out);
        end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL mid period_start got %b want 1", period_start); end
        checks++; if (d != e.duty || h != e.highs) begin errors++; $display("FAIL mid current got %0d/%0d want %0d/%0d", d, h, e.duty, e.highs); end
        e = sb.pop_front();
        measure(d, h, ok);
        checks++; if (!ok || d != e.duty || h != e.highs) begin errors++; $display("FAIL mid next got %0d/%0d want %0d/%0d", d, h, e.duty, e.highs); end
    endtask

    task automatic test_fault;
        int pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        int cnt = 0, n, ef;
        for (int i = 0; i < 8; i++) begin
            cnt = pat[i] ? cnt + 1 : 0;
            fq.push_back(cnt >= 4 ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            sat = pat[i][0];
            n = 0;
            do begin @(negedge clk); n++; end while (!period_start && !fault && n < 150);
            ef = fq.pop_front();
            checks++; if (n != 100) begin errors++; $display("FAIL fault spacing %0d got %0d want 100", i, n); end
            checks++; if (int'(fault) != ef) begin errors++; $display("FAIL fault bnd %0d got %b want %0d", i, fault, ef); end
        end
        checks++; if (pwm_out !== 1'b0 || duty_active !== 8'd0) begin errors++; $display("FAIL trip outputs got %b/%0d want 0/0", pwm_out, duty_active); end
        sat = 0; clr_fault = 1;
        repeat (5) @(negedge clk);
        checks++; if (fault !== 1'b1 || pwm_out !== 1'b0) begin errors++; $display("FAIL clr_en1 got %b/%b want 1/0", fault, pwm_out); end
        en = 0;
        @(negedge clk);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clr got %b want 0", fault); end
        clr_fault = 0;
        @(negedge clk);
    endtask

    task automatic test_en_drop;
        int d, h; bit ok; exp_t e;
        percent = 60; en = 1;
        for (int k = 1; k <= 6; k++) sb.push_back('{k * 10, k * 10});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            measure(d, h, ok);
            checks++; if (!ok || d != e.duty || h != e.highs) begin errors++; $display("FAIL ramp60 got %0d/%0d want %0d/%0d", d, h, e.duty, e.highs); end
        end
        checks++; if (duty_active !== 8'd60) begin errors++; $display("FAIL run60 duty got %0d want 60", duty_active); end
        repeat (20) @(negedge clk);
        en = 0;
        @(negedge clk);
        checks++; if (pwm_out !== 1'b0 || duty_active !== 8'd0) begin errors++; $display("FAIL en_drop got %b/%0d want 0/0", pwm_out, duty_active); end
        repeat (5) @(negedge clk);
        checks++; if (pwm_out !== 1'b0 || period_start !== 1'b0) begin errors++; $display("FAIL idle got %b/%b want 0/0", pwm_out, period_start); end
        en = 1;
        sb.push_back('{10, 10});
        e = sb.pop_front();
        measure(d, h, ok);
        checks++; if (!ok || d != e.duty || h != e.highs) begin errors++; $display("FAIL restart got %0d/%0d want %0d/%0d", d, h, e.duty, e.highs); end
    endtask

    task automatic test_reset_mid;
        percent = 90;
        repeat (50) @(negedge clk);
        rst = 1;
        @(negedge clk);
        checks++; if (pwm_out !== 1'b0 || duty_active !== 8'd0 || period_start !== 1'b0 || fault !== 1'b0)
            begin errors++; $display("FAIL rst_mid got %b/%0d/%b/%b want 0/0/0/0", pwm_out, duty_active, period_start, fault); end
        rst = 0; en = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_soft_start;
        test_extremes;
        test_mid_period;
        test_fault;
        test_en_drop;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
